multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I core variant. It sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction.
- Replaces the single-cycle decode path with a state machine. Drives PC, IR, memory, register-file and ALU-mux enables.
- Handshakes with unified memory through mem_ready.
- Evaluates beq/bne/blt from the ALU flags.

Parameters:
- RESET_STATE, 4'd0, state encoding entered on reset (FETCH). Changing it is not supported; the parameter is for documentation only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  7  instruction[6:0] from the IR.
- funct3  input  3  instruction[14:12].
- funct7_5  input  1  instruction[30].
- zero_flag  input  1  ALU result == 0.
- sign_flag  input  1  ALU result[31].
- mem_ready  input  1  memory has completed the current read/write this cycle.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- adr_src  output  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR and OldPC.
- pc_write  output  1  load PC from the result mux.
- reg_write  output  1  register file write.
- result_src  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  output  2  ALU A: 00 PC, 01 OldPC, 10 A register.
- alu_src_b  output  2  ALU B: 00 B register, 01 ImmExt, 10 constant 4.
- alu_control  output  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
- imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal_op  output  1  one-cycle pulse on an undecoded opcode.
- state_dbg  output  4  current state encoding.

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10.
- Reset: when rst is high at a rising edge, state <= FETCH.
- While rst is high, every output except state_dbg is forced to 0 combinationally, including mid-transaction (for example, mem_write drops in the same cycle). Reset has priority over every transition.
- Outputs not listed for a state are 0.
- imm_src is decoded from opcode in every state: lw/I-type 00, sw 01, branch 10, jal 11, others 00.
- FETCH:
  - Drive mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=000, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Drive alu_src_a=01, alu_src_b=01, alu_control=000, computing the branch/jump target into ALUOut.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL (only if enabled).
  - Any other opcode → FETCH with illegal_op=1 for that cycle.
- MEMADR:
  - Drive alu_src_a=10, alu_src_b=01, alu_control=000.
  - Next state: lw → MEMREAD; sw → MEMWRITE.
- MEMREAD:
  - Drive mem_read=1, adr_src=1.
  - Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1; next state FETCH.
- MEMWRITE:
  - Drive mem_write=1, adr_src=1.
  - Hold until mem_ready=1, then go to FETCH.
- EXECR / EXECI: alu_src_a=10; alu_src_b is 00 in EXECR and 01 in EXECI. Next state ALUWB.
- ALU decode in EXECR/EXECI:
  - funct3 000 gives 010 if opcode[5] & funct7_5, else 000.
  - funct3 001, 100, 101, 110, 111 map to the same 3-bit code as funct3.
  - funct3 010 and 011 give 000.
- ALUWB: result_src=00, reg_write=1; next state FETCH.
- BRANCH:
  - Drive alu_src_a=10, alu_src_b=00, alu_control=010, result_src=00.
  - pc_write is combinational on the flags:
    - funct3 000 (beq): pc_write = zero_flag.
    - funct3 001 (bne): pc_write = ~zero_flag.
    - funct3 100 (blt): pc_write = sign_flag.
    - other funct3: pc_write = 0.
  - Next state FETCH.
- Latencies with a zero-wait memory:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R/I-type: 4 cycles.
  - branch: 3 cycles.
  - jal: 4 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Unused state codes 11–15 go to FETCH on the next edge with all outputs 0.

Optional Feature:
- Macro MCCTRL_JAL_EN.
- When defined:
  - Opcode 1101111 decodes in DECODE and goes to JAL.
  - JAL drives alu_src_a=01, alu_src_b=10, alu_control=000, result_src=00, pc_write=1. This loads the PC with the target and computes OldPC+4.
  - Next state ALUWB, which writes OldPC+4 to rd.
- When undefined: 1101111 is illegal (illegal_op pulse, return to FETCH) and state 10 is unreachable.

Test Plan:
- Reset: hold rst high 2 cycles, with mem_write forced high via a mid-sw reset → outputs all 0 while rst high; state_dbg=0 after the edge; mem_read=1 on the first cycle after rst falls.
- Fetch stall: mem_ready=0 for 3 cycles, then 1 → state stays 0 with ir_write=0 and pc_write=0 for 3 cycles; ir_write=pc_write=1 on cycle 4; DECODE follows.
- lw, opcode 0000011, zero-wait memory → state sequence 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4.
- sub, opcode 0110011, funct3 000, funct7_5=1 → alu_control=010 in EXECR; same with funct7_5=0 → 000; reg_write=1 in ALUWB.
- Branches: beq with zero_flag=1 → pc_write=1 in BRANCH; bne with zero_flag=1 → pc_write=0; blt with sign_flag=1 → pc_write=1.
- Opcode 1111111 → illegal_op=1 for one cycle in DECODE, then state 0. Opcode 1101111 → illegal without MCCTRL_JAL_EN; with the macro, the sequence is 0,1,10,8,0 with pc_write=1 in state 10.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Control FSM for the multi-cycle RV32I core (shared ALU, unified
//            memory port). Optional jal support with macro MCCTRL_JAL_EN.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero_flag,
    input  logic       sign_flag,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [2:0] w_alu_dec;
    logic [1:0] w_imm_dec;
    logic       w_br_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
`ifdef MCCTRL_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
`ifdef MCCTRL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Only subtract for R-type funct7[5]; I-type never encodes a subtract.
    always_comb begin
        case (funct3)
            3'b000:         w_alu_dec = (opcode[5] & funct7_5) ? 3'b010 : 3'b000;
            3'b010, 3'b011: w_alu_dec = 3'b000;
            default:        w_alu_dec = funct3;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   w_imm_dec = 2'b01;
            OP_BR:   w_imm_dec = 2'b10;
            OP_JAL:  w_imm_dec = 2'b11;
            default: w_imm_dec = 2'b00;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  w_br_take = zero_flag;
            3'b001:  w_br_take = ~zero_flag;
            3'b100:  w_br_take = sign_flag;
            default: w_br_take = 1'b0;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        imm_src     = 2'b00;
        illegal_op  = 1'b0;
        if (!rst) begin
            if (state_q <= S_JAL) begin
                imm_src = w_imm_dec;
            end
            case (state_q)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                S_DECODE: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    illegal_op = (state_d == S_FETCH);
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = w_alu_dec;
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = w_alu_dec;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = 3'b010;
                    pc_write    = w_br_take;
                end
`ifdef MCCTRL_JAL_EN
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
`endif
                default: begin
                    imm_src = 2'b00;
                end
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Scoreboard bench: per-cycle expected state/outputs are queued by
//            the stimulus and popped/compared on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_BR  = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero_flag;
    logic       sign_flag;
    logic       mem_ready;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic [3:0] state_dbg;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero_flag(zero_flag), .sign_flag(sign_flag), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [17:0] o;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_cur;
    int   checks   = 0;
    int   failures = 0;

    wire [17:0] w_obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                         result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e_cur = sb_q.pop_front();
            check({e_cur.tag, "/state"}, {28'd0, state_dbg}, {28'd0, e_cur.st});
            check({e_cur.tag, "/outs"}, {14'd0, w_obs}, {14'd0, e_cur.o});
        end
    end

    // Output vector: mr mw as irw pcw rw rs[2] sa[2] sb[2] ac[3] imm[2] ill
    function automatic logic [17:0] ov(input logic mr, input logic mw, input logic as_,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sbv, input logic [2:0] ac,
                                       input logic [1:0] imm, input logic ill);
        return {mr, mw, as_, irw, pcw, rw, rs, sa, sbv, ac, imm, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy, input logic [1:0] imm);
        return ov(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction

    function automatic logic [17:0] e_dec(input logic [1:0] imm, input logic ill);
        return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
    endfunction

    function automatic logic [17:0] e_madr(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0);
    endfunction

    function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0);
    endfunction

    task automatic step(input string tag, input logic [3:0] st, input logic [17:0] o);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.o   = o;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic is_r, input logic [2:0] f3,
                           input logic f75, input logic [2:0] ac);
        opcode    = is_r ? C_R : C_I;
        funct3    = f3;
        funct7_5  = f75;
        mem_ready = 1'b1;
        step({tag, "_f"}, 4'd0, e_fetch(1, 2'b00));
        step({tag, "_d"}, 4'd1, e_dec(2'b00, 0));
        if (is_r)
            step({tag, "_ex"}, 4'd6, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, 2'b00, 0));
        else
            step({tag, "_ex"}, 4'd7, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ac, 2'b00, 0));
        step({tag, "_wb"}, 4'd8, e_aluwb(2'b00));
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                          input logic s, input logic take);
        opcode    = C_BR;
        funct3    = f3;
        zero_flag = z;
        sign_flag = s;
        mem_ready = 1'b1;
        step({tag, "_f"}, 4'd0, e_fetch(1, 2'b10));
        step({tag, "_d"}, 4'd1, e_dec(2'b10, 0));
        step({tag, "_br"}, 4'd9, ov(0, 0, 0, 0, take, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b10, 0));
    endtask

    initial begin
        rst = 1'b1; opcode = C_SW; funct3 = 3'b010; funct7_5 = 1'b0;
        zero_flag = 1'b0; sign_flag = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then a sw interrupted by reset while mem_write is high
        step("init_rst", 4'd0, 18'd0);
        rst = 1'b0;
        step("sw0_f", 4'd0, e_fetch(1, 2'b01));
        step("sw0_d", 4'd1, e_dec(2'b01, 0));
        step("sw0_ma", 4'd2, e_madr(2'b01));
        mem_ready = 1'b0;
        step("sw0_mw", 4'd5, ov(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
        rst = 1'b1;
        step("rst_mid", 4'd5, 18'd0);
        step("rst_hold", 4'd0, 18'd0);
        rst = 1'b0;

        // Fetch stall, then lw with mem_ready ignored in DECODE/MEMADR and a read wait
        opcode = C_LW;
        for (int i = 0; i < 3; i++) step("fstall", 4'd0, e_fetch(0, 2'b00));
        mem_ready = 1'b1;
        step("fgo", 4'd0, e_fetch(1, 2'b00));
        mem_ready = 1'b0;
        step("lw_d", 4'd1, e_dec(2'b00, 0));
        step("lw_ma", 4'd2, e_madr(2'b00));
        step("lw_mrwait", 4'd3, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        mem_ready = 1'b1;
        step("lw_mr", 4'd3, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        step("lw_wb", 4'd4, ov(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));

        // Zero-wait sw
        opcode = C_SW;
        step("sw1_f", 4'd0, e_fetch(1, 2'b01));
        step("sw1_d", 4'd1, e_dec(2'b01, 0));
        step("sw1_ma", 4'd2, e_madr(2'b01));
        step("sw1_mw", 4'd5, ov(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));

        run_alu("sub",  1'b1, 3'b000, 1'b1, 3'b010);
        run_alu("add",  1'b1, 3'b000, 1'b0, 3'b000);
        run_alu("or",   1'b1, 3'b110, 1'b0, 3'b110);
        run_alu("slt",  1'b1, 3'b010, 1'b0, 3'b000);
        run_alu("addi", 1'b0, 3'b000, 1'b1, 3'b000);
        run_alu("xori", 1'b0, 3'b100, 1'b0, 3'b100);

        run_br("beq_t", 3'b000, 1'b1, 1'b0, 1'b1);
        run_br("beq_n", 3'b000, 1'b0, 1'b0, 1'b0);
        run_br("bne_n", 3'b001, 1'b1, 1'b0, 1'b0);
        run_br("bne_t", 3'b001, 1'b0, 1'b0, 1'b1);
        run_br("blt_t", 3'b100, 1'b0, 1'b1, 1'b1);
        run_br("bx_n",  3'b110, 1'b1, 1'b1, 1'b0);

        opcode = C_BAD;
        step("bad_f", 4'd0, e_fetch(1, 2'b00));
        step("bad_d", 4'd1, e_dec(2'b00, 1));

        opcode = C_JAL;
        step("jal_f", 4'd0, e_fetch(1, 2'b11));
`ifdef MCCTRL_JAL_EN
        step("jal_d", 4'd1, e_dec(2'b11, 0));
        step("jal_j", 4'd10, ov(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
        step("jal_wb", 4'd8, e_aluwb(2'b11));
`else
        step("jal_ill", 4'd1, e_dec(2'b11, 1));
`endif

        opcode = C_LW;
        mem_ready = 1'b0;
        step("end_f", 4'd0, e_fetch(0, 2'b00));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
